// File: rtl/p_alu_exec_unit.sv
// p_alu_exec_unit
//   EX-stage execution unit. It combines three pieces:
//   - the ALU-control decoder (P_ALUOp/P_funct -> P_ctrl),
//   - a registered single-cycle ALU,
//   - a shift-add iterative multiplier with HI/LO registers.
//   A valid/ready handshake lets a multiply stall the front end.
//
// Ports
//   P_clk, P_rst_n   clock (rising edge), synchronous active-low reset
//   P_in_valid       operation presented this cycle
//   P_in_ready       unit can accept an operation (IDLE and not in reset)
//   P_ALUOp          main-control op class
//   P_funct          R-type funct field
//   P_shamt          shift amount, applied to P_b
//   P_a, P_b         operands
//   P_ctrl           combinational decoded ALU control (debug/hazard)
//   P_out_valid      one-cycle pulse qualifying P_result/P_zero/P_ovf
//   P_result         registered result
//   P_zero           registered P_result == 0
//   P_ovf            registered signed overflow (add/sub/addi only)
//   P_busy           multiplier iterating
module p_alu_exec_unit #(
   parameter int WIDTH       = 32,
   parameter int SHAMT_W     = 5,
   parameter int ENABLE_MULT = 1
) (
   input  logic               P_clk,
   input  logic               P_rst_n,
   input  logic               P_in_valid,
   output logic               P_in_ready,
   input  logic [2:0]         P_ALUOp,
   input  logic [5:0]         P_funct,
   input  logic [SHAMT_W-1:0] P_shamt,
   input  logic [WIDTH-1:0]   P_a,
   input  logic [WIDTH-1:0]   P_b,
   output logic [3:0]         P_ctrl,
   output logic               P_out_valid,
   output logic [WIDTH-1:0]   P_result,
   output logic               P_zero,
   output logic               P_ovf,
   output logic               P_busy
);

   typedef enum logic [3:0] {
      C_AND  = 4'b0000, C_OR   = 4'b0001, C_ADD  = 4'b0010, C_SUB  = 4'b0110,
      C_SLT  = 4'b0111, C_SLL  = 4'b1000, C_SRL  = 4'b1001, C_SRA  = 4'b1010,
      C_XOR  = 4'b1011, C_NOR  = 4'b1100, C_SLTU = 4'b1101, C_MUL  = 4'b1110,
      C_MFHL = 4'b1111
   } alu_ctrl_e;

   typedef enum logic {S_IDLE, S_MUL} state_e;

   localparam alu_ctrl_e C_MUL_OR_ADD  = (ENABLE_MULT != 0) ? C_MUL  : C_ADD;
   localparam alu_ctrl_e C_MFHL_OR_ADD = (ENABLE_MULT != 0) ? C_MFHL : C_ADD;

   state_e               state, state_nxt;
   alu_ctrl_e            ctrl;
   logic                 ovf_en;
   logic [WIDTH-1:0]     hi, lo;
   logic [WIDTH-1:0]     alu_result, add_sum, sub_diff;
   logic                 alu_ovf, add_ovf, sub_ovf;
   logic                 accept, start_mul, mul_last;

   // Multiplier working registers
   logic [2*WIDTH-1:0]   mcand, acc, acc_next, product;
   logic [WIDTH-1:0]     mplier, mag_a, mag_b;
   logic [SHAMT_W-1:0]   count;
   logic                 neg;

   // ---------------- ALU-control decode ----------------
   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      ctrl   = C_ADD;
      ovf_en = 1'b0;
      unique case (P_ALUOp)
         3'b000: begin ctrl = C_ADD; ovf_en = 1'b1; end
         3'b001: begin ctrl = C_SUB; ovf_en = 1'b1; end
         3'b010: begin
            case (P_funct)
               6'd0:         ctrl = C_SLL;
               6'd2:         ctrl = C_SRL;
               6'd3:         ctrl = C_SRA;
               6'd16, 6'd18: ctrl = C_MFHL_OR_ADD;
               6'd24, 6'd25: ctrl = C_MUL_OR_ADD;
               6'd32:        begin ctrl = C_ADD; ovf_en = 1'b1; end
               6'd33:        ctrl = C_ADD;
               6'd34:        begin ctrl = C_SUB; ovf_en = 1'b1; end
               6'd35:        ctrl = C_SUB;
               6'd36:        ctrl = C_AND;
               6'd37:        ctrl = C_OR;
               6'd38:        ctrl = C_XOR;
               6'd39:        ctrl = C_NOR;
               6'd42:        ctrl = C_SLT;
               6'd43:        ctrl = C_SLTU;
               default:      ctrl = C_ADD;
            endcase
         end
         3'b011:  ctrl = C_OR;
         3'b100:  ctrl = C_AND;
         3'b101:  ctrl = C_SLT;
         default: ctrl = C_ADD;
      endcase
   end

   assign P_ctrl = ctrl;

   // ---------------- Single-cycle ALU ----------------
   assign add_sum  = P_a + P_b;
   assign sub_diff = P_a - P_b;
   assign add_ovf  = (P_a[WIDTH-1] == P_b[WIDTH-1]) && (add_sum[WIDTH-1]  != P_a[WIDTH-1]);
   assign sub_ovf  = (P_a[WIDTH-1] != P_b[WIDTH-1]) && (sub_diff[WIDTH-1] != P_a[WIDTH-1]);
   assign alu_ovf  = ovf_en && ((ctrl == C_ADD) ? add_ovf : sub_ovf);

   always_comb begin
      alu_result = '0;
      case (ctrl)
         C_AND:  alu_result = P_a & P_b;
         C_OR:   alu_result = P_a | P_b;
         C_ADD:  alu_result = add_sum;
         C_SUB:  alu_result = sub_diff;
         C_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(P_a) < $signed(P_b))};
         C_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (P_a < P_b)};
         C_SLL:  alu_result = P_b << P_shamt;
         C_SRL:  alu_result = P_b >> P_shamt;
         C_SRA:  alu_result = $signed(P_b) >>> P_shamt;
         C_XOR:  alu_result = P_a ^ P_b;
         C_NOR:  alu_result = ~(P_a | P_b);
         C_MFHL: alu_result = P_funct[1] ? lo : hi;   // funct 18 (MFLO) has bit 1 set
         default: alu_result = '0;                    // C_MUL completes via the multiplier
      endcase
   end

   // ---------------- Handshake / FSM ----------------
   assign accept    = P_in_valid && P_in_ready;
   assign start_mul = accept && (ctrl == C_MUL);
   assign mul_last  = (state == S_MUL) && (count == SHAMT_W'(WIDTH-1));

   always_ff @(posedge P_clk) begin
      if (!P_rst_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_mul) state_nxt = S_MUL;
         S_MUL:   if (mul_last)  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      P_in_ready = (state == S_IDLE) && P_rst_n;
      P_busy     = (state == S_MUL);
   end

   // ---------------- Iterative multiplier ----------------
   // MULT (funct 24) works on magnitudes; MULTU (funct 25) uses the raw operands.
   assign mag_a    = (!P_funct[0] && P_a[WIDTH-1]) ? -P_a : P_a;
   assign mag_b    = (!P_funct[0] && P_b[WIDTH-1]) ? -P_b : P_b;
   assign acc_next = acc + (mplier[0] ? mcand : '0);
   assign product  = neg ? -acc_next : acc_next;

   // NOTE: these registers are only meaningful while state==S_MUL and are loaded on
   // every start, so they carry no reset.
   always_ff @(posedge P_clk) begin
      if (start_mul) begin
         mcand  <= {{WIDTH{1'b0}}, mag_a};
         mplier <= mag_b;
         acc    <= '0;
         count  <= '0;
         neg    <= !P_funct[0] && (P_a[WIDTH-1] ^ P_b[WIDTH-1]);
      end else if (state == S_MUL) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + SHAMT_W'(1);
      end
   end

   // ---------------- Result / HI-LO registers ----------------
   // NOTE: state elements use non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge P_clk) begin
      if (!P_rst_n) begin
         hi          <= '0;
         lo          <= '0;
         P_out_valid <= 1'b0;
         P_result    <= '0;
         P_zero      <= 1'b0;
         P_ovf       <= 1'b0;
      end else begin
         P_out_valid <= 1'b0;
         if (mul_last) begin
            {hi, lo}    <= product;
            P_out_valid <= 1'b1;
            P_result    <= product[WIDTH-1:0];
            P_zero      <= (product[WIDTH-1:0] == '0);
            P_ovf       <= 1'b0;
         end else if (accept && (ctrl != C_MUL)) begin
            P_out_valid <= 1'b1;
            P_result    <= alu_result;
            P_zero      <= (alu_result == '0);
            P_ovf       <= alu_ovf;
         end
      end
   end

endmodule

// File: tb/tb_p_alu_exec_unit.sv
// tb_p_alu_exec_unit
//   Directed vectors with hand-computed expectations for p_alu_exec_unit.
//   A second instance with ENABLE_MULT=0 covers the reduced build.
module tb_p_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, nm_valid;
   logic [2:0]  alu_op;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [31:0] a, b;

   logic        in_ready, out_valid, zero, ovf, busy;
   logic [3:0]  ctrl;
   logic [31:0] result;

   logic        nm_in_ready, nm_out_valid, nm_zero, nm_ovf, nm_busy;
   logic [3:0]  nm_ctrl;
   logic [31:0] nm_result;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   p_alu_exec_unit #(.WIDTH(32), .SHAMT_W(5), .ENABLE_MULT(1)) dut (
      .P_clk(clk), .P_rst_n(rst_n), .P_in_valid(in_valid), .P_in_ready(in_ready),
      .P_ALUOp(alu_op), .P_funct(funct), .P_shamt(shamt), .P_a(a), .P_b(b),
      .P_ctrl(ctrl), .P_out_valid(out_valid), .P_result(result), .P_zero(zero),
      .P_ovf(ovf), .P_busy(busy)
   );

   p_alu_exec_unit #(.WIDTH(32), .SHAMT_W(5), .ENABLE_MULT(0)) dut_nm (
      .P_clk(clk), .P_rst_n(rst_n), .P_in_valid(nm_valid), .P_in_ready(nm_in_ready),
      .P_ALUOp(alu_op), .P_funct(funct), .P_shamt(shamt), .P_a(a), .P_b(b),
      .P_ctrl(nm_ctrl), .P_out_valid(nm_out_valid), .P_result(nm_result), .P_zero(nm_zero),
      .P_ovf(nm_ovf), .P_busy(nm_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic set_op(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] va, input logic [31:0] vb);
      alu_op = op; funct = fn; shamt = sh; a = va; b = vb;
   endtask

   // Present one op for a single cycle and check the registered outputs next cycle.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] va, input logic [31:0] vb,
                         input logic [3:0] exp_ctrl, input logic [31:0] exp_res,
                         input logic exp_zero, input logic exp_ovf);
      @(negedge clk);
      set_op(op, fn, sh, va, vb);
      in_valid = 1'b1;
      #1 check({tag, " ctrl"}, {28'd0, ctrl}, {28'd0, exp_ctrl});
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " result"}, result, exp_res);
      check({tag, " zero"}, {31'd0, zero}, {31'd0, exp_zero});
      check({tag, " ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
   endtask

   // Multiply with P_in_valid held throughout, then an MFHI issued the cycle the
   // product appears.
   task automatic do_mul(input string tag, input logic [5:0] fn, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
      int busy_cycles = 0;
      int ready_in_busy = 0;
      int done_at = -1;
      @(negedge clk);
      set_op(3'b010, fn, 5'd0, va, vb);
      in_valid = 1'b1;
      #1 check({tag, " ctrl"}, {28'd0, ctrl}, 32'hE);
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (out_valid) begin
            done_at = i;
            check({tag, " result"}, result, exp_lo);
            check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
            set_op(3'b010, 6'd16, 5'd0, 32'd0, 32'd0);   // MFHI, back-to-back
            break;
         end
         if (busy) busy_cycles++;
         if (in_ready) ready_in_busy++;
      end
      check({tag, " latency"}, done_at, 33);
      check({tag, " busy cycles"}, busy_cycles, 32);
      check({tag, " ready while busy"}, ready_in_busy, 0);
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, " mfhi valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " mfhi"}, result, exp_hi);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      rst_n = 1'b0; in_valid = 1'b0; nm_valid = 1'b0;
      set_op(3'b000, 6'd0, 5'd0, 32'd0, 32'd0);
      repeat (3) @(negedge clk);
      check("rst ready", {31'd0, in_ready}, 32'd0);
      check("rst result", result, 32'd0);
      check("rst valid", {31'd0, out_valid}, 32'd0);
      rst_n = 1'b1;
      #1 check("post-rst ready", {31'd0, in_ready}, 32'd1);

      // op, funct, shamt, a, b, ctrl, result, zero, ovf
      run_op("add ovf",  3'b010, 6'd32, 5'd0, 32'h7FFFFFFF, 32'h1, 4'b0010, 32'h80000000, 1'b0, 1'b1);
      run_op("addu",     3'b010, 6'd33, 5'd0, 32'h7FFFFFFF, 32'h1, 4'b0010, 32'h80000000, 1'b0, 1'b0);
      run_op("beq sub",  3'b001, 6'd0,  5'd0, 32'h1234, 32'h1234,  4'b0110, 32'h0,        1'b1, 1'b0);
      // Zero flag holds while no result is issued.
      @(negedge clk);
      check("hold valid", {31'd0, out_valid}, 32'd0);
      check("hold zero", {31'd0, zero}, 32'd1);
      run_op("sra",      3'b010, 6'd3,  5'd4, 32'h0, 32'h80000000,  4'b1010, 32'hF8000000, 1'b0, 1'b0);
      run_op("srl",      3'b010, 6'd2,  5'd4, 32'h0, 32'h80000000,  4'b1001, 32'h08000000, 1'b0, 1'b0);
      run_op("sll",      3'b010, 6'd0,  5'd31, 32'h0, 32'h1,        4'b1000, 32'h80000000, 1'b0, 1'b0);
      run_op("slt",      3'b010, 6'd42, 5'd0, 32'hFFFFFFFF, 32'h1,  4'b0111, 32'h1,        1'b0, 1'b0);
      run_op("sltu",     3'b010, 6'd43, 5'd0, 32'hFFFFFFFF, 32'h1,  4'b1101, 32'h0,        1'b1, 1'b0);
      run_op("slti",     3'b101, 6'd0,  5'd0, 32'h2, 32'hFFFFFFFF,  4'b0111, 32'h0,        1'b1, 1'b0);
      run_op("xor",      3'b010, 6'd38, 5'd0, 32'hFF00FF00, 32'h0FF00FF0, 4'b1011, 32'hF0F0F0F0, 1'b0, 1'b0);
      run_op("nor",      3'b010, 6'd39, 5'd0, 32'hF0F0F0F0, 32'h0F0F0000, 4'b1100, 32'h00000F0F, 1'b0, 1'b0);
      run_op("andi",     3'b100, 6'd0,  5'd0, 32'hF0F0, 32'hFF00,  4'b0000, 32'h0000F000,   1'b0, 1'b0);
      run_op("sub ovf",  3'b010, 6'd34, 5'd0, 32'h80000000, 32'h1, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1);
      run_op("addi ovf", 3'b000, 6'd0,  5'd0, 32'h7FFFFFFF, 32'h1, 4'b0010, 32'h80000000, 1'b0, 1'b1);
      run_op("op110",    3'b110, 6'd0,  5'd0, 32'h7FFFFFFF, 32'h1, 4'b0010, 32'h80000000, 1'b0, 1'b0);
      run_op("funct63",  3'b010, 6'd63, 5'd0, 32'd10, 32'd20,      4'b0010, 32'd30,       1'b0, 1'b0);
      run_op("ori",      3'b011, 6'd0,  5'd0, 32'hF0, 32'h0F,      4'b0001, 32'hFF,       1'b0, 1'b0);

      // Back-to-back accepts give back-to-back pulses.
      @(negedge clk);
      set_op(3'b000, 6'd0, 5'd0, 32'd1, 32'd2);
      in_valid = 1'b1;
      @(negedge clk);
      check("b2b first valid", {31'd0, out_valid}, 32'd1);
      check("b2b first", result, 32'd3);
      set_op(3'b001, 6'd0, 5'd0, 32'd9, 32'd4);
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b second valid", {31'd0, out_valid}, 32'd1);
      check("b2b second", result, 32'd5);

      // Mid-stream reset for two cycles.
      @(negedge clk);
      rst_n = 1'b0;
      #1 check("mid-rst ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      check("mid-rst result", result, 32'd0);
      check("mid-rst valid", {31'd0, out_valid}, 32'd0);
      check("mid-rst zero", {31'd0, zero}, 32'd0);
      check("mid-rst ovf", {31'd0, ovf}, 32'd0);
      check("mid-rst busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("after mid-rst ready", {31'd0, in_ready}, 32'd1);

      // Multiplies: -3*7 = 0xFFFFFFFF_FFFFFFEB, 0xFFFFFFFF*2 = 0x1_FFFFFFFE.
      do_mul("mult", 6'd24, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF);
      run_op("mflo",  3'b010, 6'd18, 5'd0, 32'd0, 32'd0, 4'b1111, 32'hFFFFFFEB, 1'b0, 1'b0);
      do_mul("multu", 6'd25, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'h1);

      // Reset at iteration 10 of a MULTU aborts it without a completion pulse.
      @(negedge clk);
      set_op(3'b010, 6'd25, 5'd0, 32'hFFFFFFFF, 32'd2);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("abort busy", {31'd0, busy}, 32'd1);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort busy in rst", {31'd0, busy}, 32'd0);
      check("abort valid in rst", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("abort ready", {31'd0, in_ready}, 32'd1);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      check("abort no pulse", pulses, 0);
      run_op("abort mfhi", 3'b010, 6'd16, 5'd0, 32'd0, 32'd0, 4'b1111, 32'h0, 1'b1, 1'b0);
      run_op("abort mflo", 3'b010, 6'd18, 5'd0, 32'd0, 32'd0, 4'b1111, 32'h0, 1'b1, 1'b0);

      // ENABLE_MULT=0: MULT and MFHI decode as ADD and complete in one cycle.
      @(negedge clk);
      set_op(3'b010, 6'd24, 5'd0, 32'd5, 32'd6);
      nm_valid = 1'b1;
      #1 check("nm mult ctrl", {28'd0, nm_ctrl}, 32'h2);
      @(negedge clk);
      set_op(3'b010, 6'd16, 5'd0, 32'd7, 32'd8);
      check("nm mult valid", {31'd0, nm_out_valid}, 32'd1);
      check("nm mult result", nm_result, 32'd11);
      check("nm busy", {31'd0, nm_busy}, 32'd0);
      @(negedge clk);
      nm_valid = 1'b0;
      check("nm mfhi valid", {31'd0, nm_out_valid}, 32'd1);
      check("nm mfhi result", nm_result, 32'd15);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
